mem_access_stage: RTL and testbench

//  MEM-stage data-memory access unit between the EX/MEM register and the MEM/WB register.

---
 rtl/mem_access_stage.sv | 186 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage load/store unit driving a req/gnt/rvalid data bus
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_mem,
  input  logic        mem_write_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] write_data_mem,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic [31:0] read_data_mem,
  output logic        stall_mem,
  output logic        mem_err_mem
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;

  // A zero timeout disables the abort path; TO_LAST is the last cycle index allowed in REQ/WAIT.
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        stall;

  logic any_op, access, illegal, misaligned, bad_op, valid_op, timeout_hit;

  assign any_op      = mem_read_mem | mem_write_mem;
  assign access      = mem_read_mem ^ mem_write_mem;
  assign illegal     = (mem_read_mem & mem_write_mem) | (funct3_mem == 3'b011) |
                       (funct3_mem[2:1] == 2'b11) | (mem_write_mem & funct3_mem[2]);
  assign misaligned  = ((funct3_mem[1:0] == 2'b01) & alu_result_mem[0]) |
                       ((funct3_mem[1:0] == 2'b10) & (alu_result_mem[1:0] != 2'b00));
  assign bad_op      = any_op & (illegal | misaligned);
  assign valid_op    = access & ~illegal & ~misaligned;
  assign timeout_hit = TO_EN & (cnt_q == TO_LAST);

  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  // Store lane placement: byte/half data replicated across the word, enables select the lanes.
  always_comb begin
    st_be    = 4'hF;
    st_wdata = write_data_mem;
    case (funct3_mem[1:0])
      2'b00: begin
        st_be    = 4'b0001 << alu_result_mem[1:0];
        st_wdata = {4{write_data_mem[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << alu_result_mem[1:0];
        st_wdata = {2{write_data_mem[15:0]}};
      end
      default: ;
    endcase
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign ld_byte = dbus_rdata[{off_q, 3'b000} +: 8];
  assign ld_half = dbus_rdata[{off_q[1], 4'b0000} +: 16];

  // Load lane select and sign/zero extension using the latched width and byte offset.
  always_comb begin
    ld_ext = dbus_rdata;
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = dbus_rdata;
    endcase
  end

  // Transaction FSM: next state, request latching, timeout counting and load capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_op) begin
          stall   = 1'b1;
          we_d    = mem_write_mem;
          addr_d  = {alu_result_mem[31:2], 2'b00};
          be_d    = mem_write_mem ? st_be : 4'hF;
          wdata_d = mem_write_mem ? st_wdata : 32'h0;
          f3_d    = funct3_mem;
          off_d   = alu_result_mem[1:0];
          cnt_d   = 32'h0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + 32'h1;
        if (dbus_gnt) begin
          cnt_d   = 32'h0;
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + 32'h1;
        if (dbus_rvalid) begin
          rdata_d = ld_ext;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 32'h0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign dbus_req      = (state_q == S_REQ);
  assign dbus_we       = we_q;
  assign dbus_addr     = addr_q;
  assign dbus_be       = be_q;
  assign dbus_wdata    = wdata_q;
  assign read_data_mem = rdata_q;
  assign stall_mem     = stall;
  assign mem_err_mem   = err_q | ((state_q == S_IDLE) & bad_op);

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_mem, mem_write_mem;
  logic [2:0]  funct3_mem;
  logic [31:0] alu_result_mem, write_data_mem;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic [31:0] read_data_mem;
  logic        stall_mem, mem_err_mem;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
    .funct3_mem(funct3_mem), .alu_result_mem(alu_result_mem), .write_data_mem(write_data_mem),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
    .dbus_rdata(dbus_rdata), .read_data_mem(read_data_mem),
    .stall_mem(stall_mem), .mem_err_mem(mem_err_mem)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;

  // results of the most recent run_access
  int          r_stall, r_req;
  logic [31:0] r_addr, r_wdata, r_rdm;
  logic [3:0]  r_be;
  logic        r_we, r_err, r_hung;

  logic [2:0]  f3_tab[8] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b000, 3'b101, 3'b001};
  logic [31:0] ad_tab[8] = '{32'h400, 32'h402, 32'h401, 32'h400, 32'h404, 32'h402, 32'h402, 32'h400};

  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [31:0] b, h, r;
    b = (w >> (off * 8)) & 32'hFF;
    h = (w >> (off[1] * 16)) & 32'hFFFF;
    case (f3)
      3'b000:  r = (b > 32'h7F) ? (b | 32'hFFFFFF00) : b;
      3'b001:  r = (h > 32'h7FFF) ? (h | 32'hFFFF0000) : h;
      3'b100:  r = b;
      3'b101:  r = h;
      default: r = w;
    endcase
    return r;
  endfunction

  // Drives one instruction into MEM and plays the bus side; gnt_wait<0 means never grant.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int gnt_wait, input int rv_wait, input logic [31:0] rdata);
    int  since;
    logic granted;
    r_stall = 0; r_req = 0; r_addr = 0; r_wdata = 0; r_be = 0; r_we = 0;
    r_err = 0; r_rdm = 0; r_hung = 1; granted = 0; since = 0;
    @(posedge clk); #1;
    mem_read_mem = rd; mem_write_mem = wr; funct3_mem = f3;
    alu_result_mem = addr; write_data_mem = wd;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
      if (!stall_mem) begin
        r_err = mem_err_mem; r_rdm = read_data_mem; r_hung = 0;
        break;
      end
      r_stall++;
      if (dbus_req) begin
        if (r_req == 0) begin
          r_addr = dbus_addr; r_wdata = dbus_wdata; r_be = dbus_be; r_we = dbus_we;
        end
        r_req++;
        if (r_req - 1 == gnt_wait) begin
          dbus_gnt = 1'b1; granted = 1'b1; since = 0;
        end
      end else if (granted) begin
        since++;
        if (since == rv_wait) begin
          dbus_rvalid = 1'b1; dbus_rdata = rdata;
        end
      end
    end
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    @(posedge clk); #1;
    mem_read_mem = 1'b0; mem_write_mem = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_read_mem = 0; mem_write_mem = 0; funct3_mem = 0; alu_result_mem = 0; write_data_mem = 0;
    dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({dbus_req, dbus_we, dbus_be, stall_mem, mem_err_mem} !== 8'h0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0", {dbus_req, dbus_we, dbus_be, stall_mem, mem_err_mem});
    end
    total++;
    if ({dbus_addr, dbus_wdata, read_data_mem} !== 96'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {dbus_addr, dbus_wdata, read_data_mem});
    end
    reset = 1'b1;
    last_rd = 32'h0;
  endtask

  task automatic test_lw();
    exp_q.push_back(32'hDEADBEEF);
    run_access(1, 0, 3'b010, 32'h100, 0, 0, 2, 32'hDEADBEEF);
    total++; if (r_hung !== 1'b0) begin bad++; $display("FAIL lw_done got=hung exp=done"); end
    total++; if ({r_addr, r_be, r_we} !== {32'h100, 4'hF, 1'b0}) begin
      bad++; $display("FAIL lw_bus got=%h/%h/%b exp=100/f/0", r_addr, r_be, r_we); end
    total++; if (r_stall !== 4) begin bad++; $display("FAIL lw_stall got=%0d exp=4", r_stall); end
    total++; if (r_rdm !== exp_q[0]) begin bad++; $display("FAIL lw_data got=%h exp=%h", r_rdm, exp_q[0]); end
    last_rd = exp_q.pop_front();
  endtask

  task automatic test_lb();
    exp_q.push_back(32'hFFFFFF80);
    run_access(1, 0, 3'b000, 32'h103, 0, 1, 1, 32'h80FFFFFF);
    total++; if (r_be !== 4'hF) begin bad++; $display("FAIL lb_be got=%h exp=f", r_be); end
    total++; if (r_rdm !== exp_q[0]) begin bad++; $display("FAIL lb_data got=%h exp=%h", r_rdm, exp_q[0]); end
    last_rd = exp_q.pop_front();
    exp_q.push_back(32'h00000080);
    run_access(1, 0, 3'b100, 32'h103, 0, 0, 1, 32'h80FFFFFF);
    total++; if (r_rdm !== exp_q[0]) begin bad++; $display("FAIL lbu_data got=%h exp=%h", r_rdm, exp_q[0]); end
    last_rd = exp_q.pop_front();
  endtask

  task automatic test_store();
    run_access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 0, 1, 32'h0);
    total++; if ({r_we, r_be, r_wdata, r_addr} !== {1'b1, 4'b1100, 32'hABCDABCD, 32'h200}) begin
      bad++; $display("FAIL sh_bus got=%b/%b/%h/%h exp=1/1100/abcdabcd/200", r_we, r_be, r_wdata, r_addr); end
    total++; if (r_stall !== 2) begin bad++; $display("FAIL sh_stall got=%0d exp=2", r_stall); end
    total++; if (r_rdm !== last_rd) begin bad++; $display("FAIL sh_hold got=%h exp=%h", r_rdm, last_rd); end
    run_access(0, 1, 3'b000, 32'h501, 32'h000000EF, 1, 1, 32'h0);
    total++; if ({r_be, r_wdata, r_stall} !== {4'b0010, 32'hEFEFEFEF, 32'd3}) begin
      bad++; $display("FAIL sb_bus got=%b/%h/%0d exp=0010/efefefef/3", r_be, r_wdata, r_stall); end
    run_access(0, 1, 3'b010, 32'h504, 32'h11223344, 0, 1, 32'h0);
    total++; if ({r_be, r_wdata} !== {4'hF, 32'h11223344}) begin
      bad++; $display("FAIL sw_bus got=%h/%h exp=f/11223344", r_be, r_wdata); end
  endtask

  task automatic test_illegal();
    run_access(1, 0, 3'b010, 32'h101, 0, 0, 1, 32'h0);
    total++; if ({r_req, r_stall, r_err} !== {32'd0, 32'd0, 1'b1}) begin
      bad++; $display("FAIL misalign got=req%0d/stall%0d/err%b exp=0/0/1", r_req, r_stall, r_err); end
    run_access(1, 0, 3'b011, 32'h100, 0, 0, 1, 32'h0);
    total++; if ({r_req, r_stall, r_err} !== {32'd0, 32'd0, 1'b1}) begin
      bad++; $display("FAIL f3_011 got=req%0d/stall%0d/err%b exp=0/0/1", r_req, r_stall, r_err); end
    run_access(0, 1, 3'b100, 32'h100, 0, 0, 1, 32'h0);
    total++; if ({r_req, r_err} !== {32'd0, 1'b1}) begin
      bad++; $display("FAIL st_unsigned got=req%0d/err%b exp=0/1", r_req, r_err); end
    run_access(1, 1, 3'b010, 32'h100, 0, 0, 1, 32'h0);
    total++; if ({r_req, r_err} !== {32'd0, 1'b1}) begin
      bad++; $display("FAIL rd_and_wr got=req%0d/err%b exp=0/1", r_req, r_err); end
    @(negedge clk);
    total++; if ({dbus_req, stall_mem, mem_err_mem} !== 3'b000) begin
      bad++; $display("FAIL illegal_idle got=%b exp=000", {dbus_req, stall_mem, mem_err_mem}); end
  endtask

  task automatic test_timeout();
    run_access(1, 0, 3'b010, 32'h300, 0, -1, 1, 32'h0);
    total++; if (r_req !== 4) begin bad++; $display("FAIL to_req got=%0d exp=4", r_req); end
    total++; if ({r_err, r_rdm} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL to_done got=err%b/%h exp=1/0", r_err, r_rdm); end
    total++; if (r_stall !== 5) begin bad++; $display("FAIL to_stall got=%0d exp=5", r_stall); end
    @(negedge clk);
    total++; if (mem_err_mem !== 1'b0) begin bad++; $display("FAIL to_pulse got=%b exp=0", mem_err_mem); end
    last_rd = 32'h0;
  endtask

  task automatic test_ignore();
    @(negedge clk);
    dbus_gnt = 1'b1; dbus_rvalid = 1'b1; dbus_rdata = 32'h55555555;
    @(negedge clk);
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    total++; if ({dbus_req, stall_mem, read_data_mem} !== {2'b00, last_rd}) begin
      bad++; $display("FAIL ignore got=%b/%h exp=00/%h", {dbus_req, stall_mem}, read_data_mem, last_rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    int g, v;
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      g = $urandom_range(0, 2);
      v = $urandom_range(1, 2);
      exp_q.push_back(load_model(f3_tab[i], ad_tab[i][1:0], w));
      run_access(1, 0, f3_tab[i], ad_tab[i], 0, g, v, w);
      total++; if (r_hung !== 1'b0 || r_stall !== 2 + g + v) begin
        bad++; $display("FAIL b2b_stall[%0d] got=%0d exp=%0d", i, r_stall, 2 + g + v); end
      total++; if (exp_q.size() == 0 || r_rdm !== exp_q[0]) begin
        bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, r_rdm, exp_q.size() ? exp_q[0] : 32'h0); end
      if (exp_q.size() != 0) last_rd = exp_q.pop_front();
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    found = 1'b0;
    @(posedge clk); #1;
    mem_read_mem = 1; funct3_mem = 3'b010; alu_result_mem = 32'h600;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dbus_req) begin dbus_gnt = 1'b1; found = 1'b1; break; end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL rm_req got=none exp=req"); end
    @(negedge clk);
    dbus_gnt = 1'b0;
    total++; if ({dbus_req, stall_mem} !== 2'b01) begin
      bad++; $display("FAIL rm_wait got=%b exp=01", {dbus_req, stall_mem}); end
    reset = 1'b0; mem_read_mem = 1'b0;
    #1;
    total++; if ({dbus_req, stall_mem, read_data_mem} !== 34'h0) begin
      bad++; $display("FAIL rm_async got=%b/%h exp=00/0", {dbus_req, stall_mem}, read_data_mem); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); dbus_rvalid = 1'b1; dbus_rdata = 32'hCAFEF00D;
    @(negedge clk); dbus_rvalid = 1'b0;
    total++; if ({dbus_req, stall_mem, read_data_mem} !== 34'h0) begin
      bad++; $display("FAIL rm_late got=%b/%h exp=00/0", {dbus_req, stall_mem}, read_data_mem); end
    last_rd = 32'h0;
    exp_q.push_back(32'hFFFF8001);
    run_access(1, 0, 3'b001, 32'h702, 0, 0, 1, 32'h80011234);
    total++; if (r_rdm !== exp_q[0]) begin bad++; $display("FAIL rm_recover got=%h exp=%h", r_rdm, exp_q[0]); end
    last_rd = exp_q.pop_front();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb();
    test_store();
    test_illegal();
    test_timeout();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
